// File: rtl/transpose_stream.sv
// Streaming matrix transpose with two ping-pong banks: one bank loads
// while the other drains, so a full matrix can stream every SIZE_A*SIZE_B cycles.
module transpose_stream #(
  parameter int unsigned SIZE_A = 8,
  parameter int unsigned SIZE_B = 8,
  parameter int unsigned N_BITS = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              transpose_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N_BITS-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_BITS-1:0] out_data,
  output logic              out_last
);

  localparam int unsigned N     = SIZE_A * SIZE_B;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned I_W   = (SIZE_B > 1) ? $clog2(SIZE_B) : 1;
  localparam int unsigned J_W   = (SIZE_A > 1) ? $clog2(SIZE_A) : 1;

  typedef enum logic [1:0] {
    B_EMPTY    = 2'd0,
    B_FILLING  = 2'd1,
    B_FULL     = 2'd2,
    B_DRAINING = 2'd3
  } bank_st_t;

  bank_st_t          bank_q [2];
  bank_st_t          bank_d [2];
  logic [1:0]        mode_q, mode_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [I_W-1:0]    rd_i_q, rd_i_d;
  logic [J_W-1:0]    rd_j_q, rd_j_d;
  logic              out_valid_d, out_last_d, in_ready_d;
  logic [N_BITS-1:0] out_data_d;

  logic [N_BITS-1:0] mem [2][N];

  logic              in_fire;
  logic              last_fire;
  logic              start;
  logic              fetch_cur;
  logic              fetch_next;
  logic              load;
  logic              src;
  logic [CNT_W-1:0]  rd_addr;
  logic [N_BITS-1:0] rd_data;

  // Handshake qualifiers; clr suppresses any beat in its cycle.
  assign in_fire    = in_valid && in_ready && !clr;
  assign last_fire  = out_valid && out_ready && out_last;
  // First element of a freshly FULL bank needs one setup cycle when the read side is idle.
  assign start      = !out_valid && (bank_q[rd_bank_q] == B_FULL);
  assign fetch_cur  = (bank_q[rd_bank_q] == B_DRAINING) && !(out_valid && out_last);
  // Chain straight into the other bank on the last beat so no bubble appears between matrices.
  assign fetch_next = last_fire && (bank_q[~rd_bank_q] == B_FULL);
  assign load       = (!out_valid || out_ready) && (fetch_cur || fetch_next);
  assign src        = fetch_next ? ~rd_bank_q : rd_bank_q;

  // Element address: column-major walk for transpose, linear for bypass.
  assign rd_addr = mode_q[src] ? (CNT_W'(rd_j_q) * CNT_W'(SIZE_B) + CNT_W'(rd_i_q)) : rd_cnt_q;
  assign rd_data = mem[src][rd_addr];

  // Element storage; contents survive reset and clr.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      mem[wr_bank_q][wr_cnt_q] <= in_data;
    end
  end

  // Next-state for bank states, counters and registered outputs.
  always_comb begin
    bank_d[0]   = bank_q[0];
    bank_d[1]   = bank_q[1];
    mode_d      = mode_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    rd_i_d      = rd_i_q;
    rd_j_d      = rd_j_q;
    out_valid_d = out_valid;
    out_data_d  = out_data;
    out_last_d  = out_last;
    in_ready_d  = 1'b0;

    if (in_fire) begin
      if (bank_q[wr_bank_q] == B_EMPTY) begin
        bank_d[wr_bank_q] = B_FILLING;
        mode_d[wr_bank_q] = transpose_en;
      end
      if (wr_cnt_q == CNT_W'(N - 1)) begin
        bank_d[wr_bank_q] = B_FULL;
        wr_cnt_d          = '0;
        wr_bank_d         = ~wr_bank_q;
      end else begin
        wr_cnt_d = wr_cnt_q + CNT_W'(1);
      end
    end

    if (start) begin
      bank_d[rd_bank_q] = B_DRAINING;
    end
    if (last_fire) begin
      bank_d[rd_bank_q] = B_EMPTY;
      rd_bank_d         = ~rd_bank_q;
    end
    if (fetch_next) begin
      bank_d[~rd_bank_q] = B_DRAINING;
    end

    if (load) begin
      out_valid_d = 1'b1;
      out_data_d  = rd_data;
      out_last_d  = (rd_cnt_q == CNT_W'(N - 1));
      rd_cnt_d    = (rd_cnt_q == CNT_W'(N - 1)) ? '0 : rd_cnt_q + CNT_W'(1);
      if (rd_j_q == J_W'(SIZE_A - 1)) begin
        rd_j_d = '0;
        rd_i_d = (rd_i_q == I_W'(SIZE_B - 1)) ? '0 : rd_i_q + I_W'(1);
      end else begin
        rd_j_d = rd_j_q + J_W'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (clr) begin
      bank_d[0]   = B_EMPTY;
      bank_d[1]   = B_EMPTY;
      mode_d      = '0;
      wr_bank_d   = 1'b0;
      rd_bank_d   = 1'b0;
      wr_cnt_d    = '0;
      rd_cnt_d    = '0;
      rd_i_d      = '0;
      rd_j_d      = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
      out_last_d  = 1'b0;
    end

    in_ready_d = (bank_d[wr_bank_d] == B_EMPTY) || (bank_d[wr_bank_d] == B_FILLING);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank_q[0] <= B_EMPTY;
      bank_q[1] <= B_EMPTY;
      mode_q    <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_cnt_q  <= '0;
      rd_cnt_q  <= '0;
      rd_i_q    <= '0;
      rd_j_q    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      in_ready  <= 1'b0;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      mode_q    <= mode_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_cnt_q  <= wr_cnt_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_i_q    <= rd_i_d;
      rd_j_q    <= rd_j_d;
      out_valid <= out_valid_d;
      out_data  <= out_data_d;
      out_last  <= out_last_d;
      in_ready  <= in_ready_d;
    end
  end

endmodule
